bcd_conv_scheduler: RTL and testbench
=====================================

// Module: bcd_conv_scheduler
// PURPOSE
//  Time-shares one bcd_converter (bin->bcd) between N_REQ requesters (score, timer, lives, ...).
//  - Round-robin arbitrates requests and drives the converter input.
//  - Waits CONV_LAT cycles, then stores the BCD result in a per-requester slot for the display path.
//  - Sits between the game-state logic and the 7-seg/HUD drivers.
// PARAMETERS
//  N_REQ           4    number of requesters (2..8)
//  INPUT_WIDTH     11   binary width per requester
//  DECIMAL_DIGITS  4    BCD digits per result; elaboration error if 2**INPUT_WIDTH-1 > 10**DECIMAL_DIGITS-1
//  CONV_LAT        0    converter pipeline depth in cycles (0 = combinational converter)
// PORTS
//  clka       in   1                        system clock, all logic on rising edge
//  rst        in   1                        synchronous reset, active-high
//  req_valid  in   N_REQ                    level request, held until req_ack; may withdraw before ack
//  req_bin    in   N_REQ*INPUT_WIDTH        packed binary values, requester i at [i*IW +: IW]
//  req_ack    out  N_REQ                    one-cycle pulse: value of requester i captured
//  conv_bin   out  INPUT_WIDTH              to converter .bin (registered)
//  conv_bcd   in   DECIMAL_DIGITS*4         from converter .bcd
//  res_bcd    out  N_REQ*DECIMAL_DIGITS*4   latest BCD per requester, slot i at [i*4D +: 4D]
//  res_valid  out  N_REQ                    one-cycle pulse: slot i updated
//  busy       out  1                        high while state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, conv_bin=0, req_ack=0, res_valid=0, res_bcd=0, busy=0, lat_cnt=0.
//  - All outputs registered. FSM states: IDLE, CONV, STORE.
//  - IDLE, edge E0 with any req_valid high:
//    - Grant first set bit scanning rr_ptr, rr_ptr+1, ... (mod N_REQ).
//    - Load conv_bin=req_bin[g], grant_idx=g, lat_cnt=CONV_LAT.
//    - Pulse req_ack[g] for the cycle after E0; go to CONV.
//  - CONV: each edge with lat_cnt!=0 decrements it; edge with lat_cnt==0 goes to STORE.
//  - STORE edge: res_bcd slot[grant_idx]=conv_bcd, res_valid[grant_idx]=1 for one cycle,
//    rr_ptr=(grant_idx+1) mod N_REQ, go to IDLE.
//  - Latency: grant edge E0 -> res_valid high after edge E0+CONV_LAT+2.
//    Throughput is one conversion per CONV_LAT+3 cycles.
//  - conv_bin holds its value from grant until the next grant; it never changes in CONV or STORE.
//  - req_valid or req_bin changes after ack do not affect the in-flight conversion.
//  - A request withdrawn before grant gets no ack and no result.
//  - A requester still high after its ack is treated as a new request, arbitrated fairly.
//  - Simultaneous requests are resolved purely by rr_ptr; no requester waits more than N_REQ-1 grants.
//  - Non-granted slots are never written; res_bcd holds last results indefinitely.
//  - rst in any state (including mid-CONV/STORE): immediate return to reset values.
//    In-flight result is discarded, with no res_valid and no second req_ack.
//  - Width rule: conv_bcd is taken as-is. The converter must emit valid BCD for every INPUT_WIDTH
//    value, guaranteed by the elaboration check.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//  - Adds output blank_mask out N_REQ*DECIMAL_DIGITS.
//  - Bit [i*D+d] = 1 when digit d and all higher digits of slot i are 0; digit 0 never blanked.
//  - Updated on the same edge as the res_bcd slot; reset value 0.
//  LEADING_ZERO_BLANK_EN undefined: port and logic absent; all other behaviour identical.
// TESTING (N_REQ=4, INPUT_WIDTH=11, DECIMAL_DIGITS=4, CONV_LAT=0 unless stated)
//  1. Reset: rst=1 for 2 cycles with req_valid=4'hF -> all outputs 0, busy=0, no ack during reset.
//  2. Single request, req_valid[0]=1, req_bin[0]=1024:
//     - req_ack[0] one pulse.
//     - res_valid[0] 2 cycles later, slot0=16'h1024.
//     - Repeat with CONV_LAT=3: res_valid 5 cycles after ack.
//  3. Simultaneous requests, all four valid with 0, 7, 2047, 305:
//     - Acks in order 0,1,2,3.
//     - Slots become 16'h0000, 16'h0007, 16'h2047, 16'h0305.
//  4. Fairness: req_valid[0] and [2] held high for 8 grants -> grant sequence 0,2,0,2,...
//     and never two consecutive grants to the same requester.
//  5. Reset mid-operation: assert rst during CONV (CONV_LAT=3) with value 999:
//     - No res_valid; slot stays 0.
//     - After rst release the still-high request is re-granted and slot=16'h0999.
//  6. LEADING_ZERO_BLANK_EN: results 7 -> mask 4'b1110; 0 -> 4'b1110; 2047 -> 4'b0000;
//     305 -> 4'b1000.

Source files
------------

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler that time-shares one binary-to-BCD converter between N_REQ requesters.
// Optional leading-zero blank mask output is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_conv_scheduler #(
    parameter int N_REQ          = 4,
    parameter int INPUT_WIDTH    = 11,
    parameter int DECIMAL_DIGITS = 4,
    parameter int CONV_LAT       = 0
) (
    input  logic                                clka,
    input  logic                                rst,
    input  logic [N_REQ-1:0]                    req_valid,
    input  logic [N_REQ*INPUT_WIDTH-1:0]        req_bin,
    output logic [N_REQ-1:0]                    req_ack,
    output logic [INPUT_WIDTH-1:0]              conv_bin,
    input  logic [DECIMAL_DIGITS*4-1:0]         conv_bcd,
    output logic [N_REQ*DECIMAL_DIGITS*4-1:0]   res_bcd,
    output logic [N_REQ-1:0]                    res_valid,
`ifdef LEADING_ZERO_BLANK_EN
    output logic [N_REQ*DECIMAL_DIGITS-1:0]     blank_mask,
`endif
    output logic                                busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LW = (CONV_LAT > 0) ? $clog2(CONV_LAT + 1) : 1;
    localparam int SW = DECIMAL_DIGITS * 4;

    // The converter output is used unchecked, so every binary input must fit in the digit count.
    if ((2 ** INPUT_WIDTH) - 1 > (10 ** DECIMAL_DIGITS) - 1) begin : g_width_check
        $error("bcd_conv_scheduler: INPUT_WIDTH too wide for DECIMAL_DIGITS");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_nreq_check
        $error("bcd_conv_scheduler: N_REQ must be in 2..8");
    end

    typedef enum logic [1:0] {IDLE, CONV, STORE} state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   grant_idx;
    logic [LW-1:0]   lat_cnt;
    logic [PW-1:0]   grant_next;

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic [DECIMAL_DIGITS-1:0] blank_of(input logic [SW-1:0] bcd);
        logic [DECIMAL_DIGITS-1:0] m;
        logic                      all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int d = DECIMAL_DIGITS - 1; d >= 1; d--) begin
            all_zero = all_zero & (bcd[d*4 +: 4] == 4'd0);
            m[d]     = all_zero;
        end
        return m;
    endfunction
`endif

    // First requesting index found when scanning upward from rr_ptr with wrap-around.
    always_comb begin
        int  scan_idx;
        logic found;
        grant_next = '0;
        found      = 1'b0;
        scan_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req_valid[scan_idx]) begin
                found      = 1'b1;
                grant_next = PW'(scan_idx);
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            lat_cnt    <= '0;
            conv_bin   <= '0;
            req_ack    <= '0;
            res_valid  <= '0;
            res_bcd    <= '0;
            busy       <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            blank_mask <= '0;
`endif
        end else begin
            req_ack   <= '0;
            res_valid <= '0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        conv_bin            <= req_bin[grant_next*INPUT_WIDTH +: INPUT_WIDTH];
                        grant_idx           <= grant_next;
                        lat_cnt             <= LW'(CONV_LAT);
                        req_ack[grant_next] <= 1'b1;
                        state               <= CONV;
                        busy                <= 1'b1;
                    end
                end
                CONV: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end else begin
                        state <= STORE;
                    end
                end
                STORE: begin
                    res_bcd[grant_idx*SW +: SW] <= conv_bcd;
                    res_valid[grant_idx]        <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
                    blank_mask[grant_idx*DECIMAL_DIGITS +: DECIMAL_DIGITS] <= blank_of(conv_bcd);
`endif
                    rr_ptr <= (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
                    state  <= IDLE;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Bench for bcd_conv_scheduler: a CONV_LAT=0 and a CONV_LAT=3 instance share stimulus and are
// checked every cycle against a transaction-timeline reference model.
module tb_bcd_conv_scheduler;

    localparam int N  = 4;
    localparam int IW = 11;
    localparam int D  = 4;
    localparam int LAT [2] = '{0, 3};

    logic              clka = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*IW-1:0]   req_bin;

    logic [N-1:0]      ack    [2];
    logic [N-1:0]      rv     [2];
    logic [IW-1:0]     cbin   [2];
    logic [4*D-1:0]    cbcd   [2];
    logic [N*4*D-1:0]  res    [2];
    logic              busy   [2];
`ifdef LEADING_ZERO_BLANK_EN
    logic [N*D-1:0]    bmask  [2];
`endif
    logic [4*D-1:0]    pipe1, pipe2, pipe3;

    int n_compared   = 0;
    int n_mismatched = 0;

    int          edge_cnt = 0;
    bit          m_idle  [2];
    int          m_store [2];
    int          m_grant [2];
    int          m_rr    [2];
    int          m_conv  [2];
    int          m_slot  [2][N];
    logic [N-1:0] m_ack  [2];
    logic [N-1:0] m_rv   [2];

    always #5 clka = ~clka;

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        r = '0;
        for (int d = 0; d < D; d++) r[d*4 +: 4] = 4'((v / (10 ** d)) % 10);
        return r;
    endfunction

    bcd_conv_scheduler #(.N_REQ(N), .INPUT_WIDTH(IW), .DECIMAL_DIGITS(D), .CONV_LAT(0)) dut0 (
        .clka(clka), .rst(rst), .req_valid(req_valid), .req_bin(req_bin),
        .req_ack(ack[0]), .conv_bin(cbin[0]), .conv_bcd(cbcd[0]),
        .res_bcd(res[0]), .res_valid(rv[0]),
`ifdef LEADING_ZERO_BLANK_EN
        .blank_mask(bmask[0]),
`endif
        .busy(busy[0]));

    bcd_conv_scheduler #(.N_REQ(N), .INPUT_WIDTH(IW), .DECIMAL_DIGITS(D), .CONV_LAT(3)) dut1 (
        .clka(clka), .rst(rst), .req_valid(req_valid), .req_bin(req_bin),
        .req_ack(ack[1]), .conv_bin(cbin[1]), .conv_bcd(cbcd[1]),
        .res_bcd(res[1]), .res_valid(rv[1]),
`ifdef LEADING_ZERO_BLANK_EN
        .blank_mask(bmask[1]),
`endif
        .busy(busy[1]));

    // Converter models: combinational for dut0, three-stage pipeline for dut1.
    assign cbcd[0] = to_bcd(int'(cbin[0]));
    always @(posedge clka) begin
        pipe1 <= to_bcd(int'(cbin[1]));
        pipe2 <= pipe1;
        pipe3 <= pipe2;
    end
    assign cbcd[1] = pipe3;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic modelReset(input int k);
        m_idle[k] = 1'b1;
        m_rr[k]   = 0;
        m_conv[k] = 0;
        m_grant[k] = 0;
        m_store[k] = -1;
        for (int i = 0; i < N; i++) m_slot[k][i] = 0;
    endtask

    // Timeline model: a grant at edge t acks after t, stores after t+LAT+2, frees the converter.
    task automatic modelEdge();
        edge_cnt++;
        for (int k = 0; k < 2; k++) begin
            m_ack[k] = '0;
            m_rv[k]  = '0;
            if (rst) begin
                modelReset(k);
            end else if (m_idle[k]) begin
                for (int j = 0; j < N; j++) begin
                    int i;
                    i = (m_rr[k] + j) % N;
                    if (m_idle[k] && req_valid[i]) begin
                        m_idle[k]   = 1'b0;
                        m_grant[k]  = i;
                        m_conv[k]   = int'(req_bin[i*IW +: IW]);
                        m_ack[k][i] = 1'b1;
                        m_store[k]  = edge_cnt + LAT[k] + 2;
                    end
                end
            end else if (edge_cnt == m_store[k]) begin
                m_slot[k][m_grant[k]] = m_conv[k];
                m_rv[k][m_grant[k]]   = 1'b1;
                m_rr[k]               = (m_grant[k] + 1) % N;
                m_idle[k]             = 1'b1;
            end
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < 2; k++) begin
            logic [N*4*D-1:0] exp_res;
`ifdef LEADING_ZERO_BLANK_EN
            logic [N*D-1:0]   exp_mask;
            exp_mask = '0;
`endif
            exp_res = '0;
            for (int i = 0; i < N; i++) begin
                exp_res[i*4*D +: 4*D] = to_bcd(m_slot[k][i]);
`ifdef LEADING_ZERO_BLANK_EN
                for (int d = 1; d < D; d++)
                    exp_mask[i*D + d] = (m_slot[k][i] < 10 ** d);
`endif
            end
            checkOutput($sformatf("req_ack%0d", k),   64'(ack[k]),  64'(m_ack[k]));
            checkOutput($sformatf("res_valid%0d", k), 64'(rv[k]),   64'(m_rv[k]));
            checkOutput($sformatf("busy%0d", k),      64'(busy[k]), 64'(!m_idle[k]));
            checkOutput($sformatf("conv_bin%0d", k),  64'(cbin[k]), 64'(m_conv[k]));
            checkOutput($sformatf("res_bcd%0d", k),   res[k],       exp_res);
`ifdef LEADING_ZERO_BLANK_EN
            checkOutput($sformatf("blank_mask%0d", k), 64'(bmask[k]), 64'(exp_mask));
`endif
        end
    endtask

    task automatic stepCycle();
        @(posedge clka);
        modelEdge();
        #1;
        checkAll();
        @(negedge clka);
    endtask

    task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic [N*IW-1:0] b,
                                 input int cycles);
        rst       = r;
        req_valid = v;
        req_bin   = b;
        for (int c = 0; c < cycles; c++) stepCycle();
    endtask

    initial begin
        logic [N*IW-1:0] b;
        for (int k = 0; k < 2; k++) begin
            modelReset(k);
            m_ack[k] = '0;
            m_rv[k]  = '0;
        end

        $display("[TB] reset with all requests high");
        b = {11'd305, 11'd2047, 11'd7, 11'd0};
        applyStimulus(1'b1, 4'hF, b, 2);

        $display("[TB] single request 1024");
        b = '0;
        b[0 +: IW] = 11'd1024;
        applyStimulus(1'b0, 4'b0001, b, 1);
        applyStimulus(1'b0, 4'b0000, b, 8);
        checkOutput("slot0_1024_lat0", 64'(res[0][15:0]), 64'h1024);
        checkOutput("slot0_1024_lat3", 64'(res[1][15:0]), 64'h1024);

        $display("[TB] simultaneous requests");
        applyStimulus(1'b1, 4'b0000, b, 1);
        b = {11'd305, 11'd2047, 11'd7, 11'd0};
        applyStimulus(1'b0, 4'hF, b, 24);
        applyStimulus(1'b0, 4'h0, b, 8);
        checkOutput("slots_simul_lat0", res[0], 64'h0305_2047_0007_0000);
        checkOutput("slots_simul_lat3", res[1], 64'h0305_2047_0007_0000);
`ifdef LEADING_ZERO_BLANK_EN
        checkOutput("blank_simul", 64'(bmask[0]), 64'b1000_0000_1110_1110);
`endif

        $display("[TB] fairness between requesters 0 and 2");
        applyStimulus(1'b1, 4'b0000, b, 1);
        b = {11'd0, 11'd42, 11'd0, 11'd17};
        applyStimulus(1'b0, 4'b0101, b, 48);
        applyStimulus(1'b0, 4'b0000, b, 8);
        checkOutput("fair_slot0", 64'(res[1][15:0]),  64'h0017);
        checkOutput("fair_slot2", 64'(res[1][47:32]), 64'h0042);

        $display("[TB] reset during conversion");
        applyStimulus(1'b1, 4'b0000, b, 1);
        b = '0;
        b[0 +: IW] = 11'd999;
        applyStimulus(1'b0, 4'b0001, b, 3);
        applyStimulus(1'b1, 4'b0001, b, 1);
        checkOutput("rst_mid_slot", 64'(res[1][15:0]), 64'h0000);
        applyStimulus(1'b0, 4'b0001, b, 10);
        applyStimulus(1'b0, 4'b0000, b, 8);
        checkOutput("regrant_slot", 64'(res[1][15:0]), 64'h0999);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 1500; c++) begin
            logic r;
            for (int i = 0; i < N; i++) b[i*IW +: IW] = IW'($urandom_range(0, 2047));
            r = ($urandom_range(0, 99) < 2);
            applyStimulus(r, N'($urandom), b, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
